// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: state encoding, default geometry and length field width.
package boot_pkg;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
    localparam int          DEFAULT_MAX_WORDS = 64;
    localparam int          LEN_W             = 16;

    // States in which the loader is willing to take a stream byte.
    function automatic logic accepts_byte(input state_t s);
        logic r;
        case (s)
            LEN_LO, LEN_HI, DATA, CSUM: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian 4-byte word assembler; word presents the assembled value including the byte being loaded.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  data_byte,
    output logic [31:0] word,
    output logic [1:0]  byte_cnt,
    output logic        word_ready
);

    logic [31:0] word_r;
    logic [1:0]  cnt_r;
    logic [31:0] word_s;

    // Merge the incoming byte into its lane selected by the byte counter.
    always_comb begin
        word_s = word_r;
        case (cnt_r)
            2'd0:    word_s[7:0]   = data_byte;
            2'd1:    word_s[15:8]  = data_byte;
            2'd2:    word_s[23:16] = data_byte;
            2'd3:    word_s[31:24] = data_byte;
            default: word_s        = word_r;
        endcase
    end

    // Byte lane storage and counter; counter wraps naturally after the fourth byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_r <= 32'h0000_0000;
            cnt_r  <= 2'd0;
        end else if (load) begin
            word_r <= word_s;
            cnt_r  <= cnt_r + 2'd1;
        end
    end

    assign word       = word_s;
    assign byte_cnt   = cnt_r;
    assign word_ready = load & (cnt_r == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// Byte-stream program loader that fills word memory, then releases the core and mirrors its memory port.
// Optional BOOT_CHECKSUM_EN adds a trailing XOR checksum byte verified before release.
module boot_loader
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic [31:0] core_adr,
    input  logic [31:0] core_wd,
    input  logic        core_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic        cpu_reset,
    output logic        done,
    output logic        err
);

`ifdef BOOT_CHECKSUM_EN
    localparam state_t LAST_ST = CSUM;
`else
    localparam state_t LAST_ST = DONE;
`endif

    state_t            state_r;
    state_t            next_s;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  len_s;
    logic [LEN_W-1:0]  idx_r;
    logic [LEN_W-1:0]  idx_inc_s;
    logic [31:0]       ld_adr_r;
    logic [31:0]       ld_wd_r;
    logic              ld_we_r;
    logic              in_ready_r;
    logic              cpu_reset_r;
    logic              done_r;
    logic              err_r;
    logic              xfer_s;
    logic              pack_load_s;
    logic [31:0]       pack_word_s;
    logic [1:0]        pack_cnt_s;
    logic              word_ready_s;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum_r;
`endif

    assign in_ready    = in_ready_r & ~reset;
    assign xfer_s      = in_valid & in_ready;
    assign pack_load_s = xfer_s & (state_r == DATA);
    assign len_s       = {in_data, len_r[7:0]};
    assign idx_inc_s   = idx_r + 16'd1;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .load       (pack_load_s),
        .data_byte  (in_data),
        .word       (pack_word_s),
        .byte_cnt   (pack_cnt_s),
        .word_ready (word_ready_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= LEN_LO;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode; unknown encodings fall into the safe ERROR state.
    always_comb begin
        next_s = state_r;
        case (state_r)
            LEN_LO: begin
                if (xfer_s) next_s = LEN_HI;
                else        next_s = LEN_LO;
            end
            LEN_HI: begin
                if (!xfer_s)                              next_s = LEN_HI;
                else if (len_s == 16'd0)                  next_s = LAST_ST;
                else if ({16'd0, len_s} > 32'(MAX_WORDS)) next_s = ERROR;
                else                                      next_s = DATA;
            end
            DATA: begin
                if (word_ready_s) next_s = WRITE;
                else              next_s = DATA;
            end
            WRITE: begin
                if (idx_inc_s == len_r) next_s = LAST_ST;
                else                    next_s = DATA;
            end
`ifdef BOOT_CHECKSUM_EN
            CSUM: begin
                if (!xfer_s)               next_s = CSUM;
                else if (in_data == csum_r) next_s = DONE;
                else                       next_s = ERROR;
            end
`endif
            DONE:    next_s = DONE;
            ERROR:   next_s = ERROR;
            default: next_s = ERROR;
        endcase
    end

    // Status outputs registered from the upcoming state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_r  <= 1'b1;
            cpu_reset_r <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            in_ready_r  <= accepts_byte(next_s);
            cpu_reset_r <= (next_s != DONE);
            done_r      <= (next_s == DONE);
            err_r       <= (next_s == ERROR);
        end
    end

    // Loader datapath: length capture, word index and the one-cycle write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_r    <= 16'd0;
            idx_r    <= 16'd0;
            ld_adr_r <= 32'h0000_0000;
            ld_wd_r  <= 32'h0000_0000;
            ld_we_r  <= 1'b0;
        end else begin
            ld_we_r <= word_ready_s;
            if (word_ready_s) begin
                ld_adr_r <= BASE_ADDR + {14'd0, idx_r, 2'b00};
                ld_wd_r  <= pack_word_s;
            end
            if (xfer_s && state_r == LEN_LO) len_r[7:0]  <= in_data;
            if (xfer_s && state_r == LEN_HI) len_r[15:8] <= in_data;
            if (state_r == WRITE)            idx_r       <= idx_inc_s;
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Running XOR of every data byte accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_r <= 8'h00;
        end else if (pack_load_s) begin
            csum_r <= csum_r ^ in_data;
        end
    end
`endif

    // Memory port mux: the core owns the port only once the image is loaded.
    always_comb begin
        mem_adr = ld_adr_r;
        mem_wd  = ld_wd_r;
        mem_we  = ld_we_r;
        if (state_r == DONE) begin
            mem_adr = core_adr;
            mem_wd  = core_wd;
            mem_we  = core_we;
        end else begin
            mem_adr = ld_adr_r;
            mem_wd  = ld_wd_r;
            mem_we  = ld_we_r;
        end
    end

    assign cpu_reset = cpu_reset_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: random images/gaps, expected writes queued, monitor compares.
module tb_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [31:0] core_adr = 32'h0;
    logic [31:0] core_wd = 32'h0;
    logic        core_we = 1'b0;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic        cpu_reset;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] wd;
    } wr_t;
    wr_t exp_q[$];

    boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .core_adr(core_adr), .core_wd(core_wd), .core_we(core_we),
        .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we),
        .cpu_reset(cpu_reset), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every loader write must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset === 1'b0 && mem_we === 1'b1 && done !== 1'b1) begin
            check("in_ready_during_write", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(exp_q.size() == 0), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_adr", mem_adr, e.adr);
                check("write_data", mem_wd, e.wd);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        int t;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            core_adr = $urandom; core_wd = $urandom; core_we = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        core_adr = $urandom; core_wd = $urandom; core_we = 1'($urandom);
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        core_we = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Sends a length field plus the given words; the model queues BASE+4i / word i for accepted images.
    task automatic run_image(input int nlen, input logic [31:0] words[$], input int gap, input bit bad_csum);
        logic [7:0] cs;
        bit ok;
        int t;
        cs = 8'h00;
        ok = (nlen <= MAXW);
        if (ok) begin
            for (int i = 0; i < words.size(); i++) begin
                wr_t e;
                e.adr = BASE + 32'(4 * i);
                e.wd  = words[i];
                exp_q.push_back(e);
            end
        end
        send_byte(8'(nlen), gap);
        send_byte(8'(nlen >> 8), gap);
        if (ok) begin
            for (int i = 0; i < words.size(); i++) begin
                for (int k = 0; k < 4; k++) begin
                    logic [7:0] b;
                    b = 8'(words[i] >> (8 * k));
                    cs = cs ^ b;
                    send_byte(b, gap);
                end
            end
`ifdef BOOT_CHECKSUM_EN
            send_byte(bad_csum ? (cs ^ 8'h5A) : cs, gap);
            if (bad_csum) ok = 1'b0;
`endif
        end
        t = 0;
        while (done !== 1'b1 && err !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("terminal_reached", 32'(t < 100), 32'd1);
        check("done", 32'(done), 32'(ok));
        check("err", 32'(err), 32'(!ok));
        check("cpu_reset", 32'(cpu_reset), 32'(!ok));
        check("final_in_ready", 32'(in_ready), 32'd0);
        check("writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic void rand_words(output logic [31:0] w[$], input int n);
        w.delete();
        for (int i = 0; i < n; i++) w.push_back($urandom);
    endfunction

    initial begin
        logic [31:0] w[$];
        logic [31:0] w3[$];
        logic [31:0] empty_q[$];
        empty_q.delete();

        repeat (2) @(negedge clk);
        do_reset();

        // Directed two-word image.
        w.delete(); w.push_back(32'h12345678); w.push_back(32'hDEADBEEF);
        run_image(2, w, 0, 1'b0);

        // Core mirror after DONE, same cycle.
        @(negedge clk);
        core_adr = 32'h10; core_wd = 32'hA5A5A5A5; core_we = 1'b1;
        #1;
        check("mirror_adr", mem_adr, 32'h10);
        check("mirror_wd", mem_wd, 32'hA5A5A5A5);
        check("mirror_we", 32'(mem_we), 32'd1);
        core_adr = 32'h44; core_wd = 32'h0BAD_F00D; core_we = 1'b0;
        #1;
        check("mirror_adr2", mem_adr, 32'h44);
        check("mirror_wd2", mem_wd, 32'h0BADF00D);
        check("mirror_we2", 32'(mem_we), 32'd0);

        // Zero-length image: done right after the length field.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        check("n0_done_latency", 32'(done), 32'd1);
        check("n0_cpu_reset", 32'(cpu_reset), 32'd0);
        check("n0_writes", 32'(exp_q.size()), 32'd0);

        // Oversized length is rejected.
        do_reset();
        run_image(MAXW + 1, empty_q, 0, 1'b0);

        // Largest legal image.
        do_reset();
        rand_words(w, MAXW);
        run_image(MAXW, w, 0, 1'b0);

        // Same 3-word image, gapless and gapped.
        rand_words(w3, 3);
        do_reset();
        run_image(3, w3, 0, 1'b0);
        do_reset();
        run_image(3, w3, 3, 1'b0);

        // Reset after 1.5 words, then a fresh single-word image.
        do_reset();
        rand_words(w, 3);
        begin
            wr_t e;
            e.adr = BASE; e.wd = w[0];
            exp_q.push_back(e);
        end
        send_byte(8'h03, 1);
        send_byte(8'h00, 1);
        for (int k = 0; k < 6; k++) send_byte(8'(w[k / 4] >> (8 * (k % 4))), 1);
        check("partial_first_write", 32'(exp_q.size()), 32'd0);
        do_reset();
        rand_words(w, 1);
        run_image(1, w, 2, 1'b0);

`ifdef BOOT_CHECKSUM_EN
        do_reset();
        rand_words(w, 2);
        run_image(2, w, 1, 1'b1);
`endif

        // Random images with random gaps.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            rand_words(w, int'($urandom_range(1, 6)));
            run_image(w.size(), w, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
